debug_scanner: RTL and testbench

DEBUG_SCANNER -- requirements
Module: debug_scanner

---
 rtl/debug_scanner.sv | 142 ++++++++++++++
 tb/tb_debug_scanner.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_scanner.sv
// debug_scanner
// Walks the address space of one selected display source (register file,
// data memory or instruction memory), holds each address for WAIT_CYCLES
// clocks so the source can return its read data, captures that data and
// presents it on a valid/ready output port. One scan covers addresses
// 0..LAST_ADDRESS and ends with a one-cycle done pulse.
//
// Ports
//   clock, reset                          system clock, async active-high reset
//   start                                 request a scan (honoured only in IDLE)
//   source_select                         0 reg file, 1 data mem, 2 instr mem, 3 reserved
//   display_*_address                     scan address towards each source
//   display_*_value                       read data returned by each source
//   out_valid/out_ready                   output handshake
//   out_data/out_address/out_source       captured word, its address and source
//   busy                                  high whenever a scan is in progress
//   done                                  one-cycle pulse when a scan completes
module debug_scanner #(
  parameter int WAIT_CYCLES  = 2,
  parameter int LAST_ADDRESS = 63
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  source_select,
  output logic [5:0]  display_register_address,
  output logic [5:0]  display_data_memory_address,
  output logic [5:0]  display_instruction_memory_address,
  input  logic [31:0] display_register_value,
  input  logic [31:0] display_data_memory_value,
  input  logic [31:0] display_instruction_memory_value,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [5:0]  out_address,
  output logic [1:0]  out_source,
  output logic        busy,
  output logic        done
);

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);
  localparam logic [5:0] LAST_ADDR = 6'(LAST_ADDRESS);

  localparam logic [1:0] SRC_REGISTER    = 2'd0;
  localparam logic [1:0] SRC_DATA_MEM    = 2'd1;
  localparam logic [1:0] SRC_INSTR_MEM   = 2'd2;
  localparam logic [1:0] SRC_RESERVED    = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_PRESENT,
    S_DONE
  } state_t;

  state_t      state;
  logic [5:0]  scan_address;
  logic [1:0]  source;
  logic [3:0]  wait_count;
  logic [31:0] selected_value;

  // Read data from whichever source was latched at the start of the scan.
  always_comb begin
    selected_value = '0;
    case (source)
      SRC_REGISTER:  selected_value = display_register_value;
      SRC_DATA_MEM:  selected_value = display_data_memory_value;
      SRC_INSTR_MEM: selected_value = display_instruction_memory_value;
      default:       selected_value = '0;
    endcase
  end

  // Only the source being scanned sees the scan address; the other ports
  // (and all ports while idle) are parked at address 0.
  assign display_register_address           = (busy && source == SRC_REGISTER)  ? scan_address : '0;
  assign display_data_memory_address        = (busy && source == SRC_DATA_MEM)  ? scan_address : '0;
  assign display_instruction_memory_address = (busy && source == SRC_INSTR_MEM) ? scan_address : '0;

  // Scan sequencer. The wait counter is loaded with WAIT_CYCLES when an
  // address is first driven and the data is captured on the edge where it
  // reads 1, so WAIT occupies exactly WAIT_CYCLES clocks.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      scan_address <= '0;
      source       <= '0;
      wait_count   <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_address  <= '0;
      out_source   <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && source_select != SRC_RESERVED) begin
            state        <= S_WAIT;
            source       <= source_select;
            scan_address <= '0;
            wait_count   <= WAIT_LOAD;
            busy         <= 1'b1;
          end
        end
        S_WAIT: begin
          if (wait_count == 4'd1) begin
            state       <= S_PRESENT;
            wait_count  <= '0;
            out_valid   <= 1'b1;
            out_data    <= selected_value;
            out_address <= scan_address;
            out_source  <= source;
          end else begin
            wait_count <= wait_count - 4'd1;
          end
        end
        S_PRESENT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (scan_address == LAST_ADDR) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state        <= S_WAIT;
              scan_address <= scan_address + 6'd1;
              wait_count   <= WAIT_LOAD;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debug_scanner.sv
// Testbench for debug_scanner. Two instances share clock and reset: dut_a
// with default parameters (2 wait cycles, 64 addresses) and dut_b with
// WAIT_CYCLES=3, LAST_ADDRESS=0. A transaction-level model predicts the
// sequence of words each scan should deliver and when out_valid, busy and
// done should be high, with random backpressure and random source changes.
module tb_debug_scanner;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  source_select = 2'd0;
  logic        out_ready = 1'b0;
  bit          use_b = 1'b0;

  logic [31:0] data_mem  [64];
  logic [31:0] instr_mem [64];

  logic [5:0]  a_reg_addr, a_dmem_addr, a_imem_addr;
  logic [5:0]  b_reg_addr, b_dmem_addr, b_imem_addr;
  logic        a_valid, a_busy, a_done, b_valid, b_busy, b_done;
  logic [31:0] a_data, b_data;
  logic [5:0]  a_addr, b_addr;
  logic [1:0]  a_src, b_src;
  logic        start_a, start_b;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  assign start_a = start & ~use_b;
  assign start_b = start & use_b;

  debug_scanner dut_a (
    .clock(clock), .reset(reset), .start(start_a), .source_select(source_select),
    .display_register_address(a_reg_addr),
    .display_data_memory_address(a_dmem_addr),
    .display_instruction_memory_address(a_imem_addr),
    .display_register_value(32'h100 + {26'd0, a_reg_addr}),
    .display_data_memory_value(data_mem[a_dmem_addr]),
    .display_instruction_memory_value(instr_mem[a_imem_addr]),
    .out_valid(a_valid), .out_ready(out_ready), .out_data(a_data),
    .out_address(a_addr), .out_source(a_src), .busy(a_busy), .done(a_done)
  );

  debug_scanner #(.WAIT_CYCLES(3), .LAST_ADDRESS(0)) dut_b (
    .clock(clock), .reset(reset), .start(start_b), .source_select(source_select),
    .display_register_address(b_reg_addr),
    .display_data_memory_address(b_dmem_addr),
    .display_instruction_memory_address(b_imem_addr),
    .display_register_value(32'h100 + {26'd0, b_reg_addr}),
    .display_data_memory_value(data_mem[b_dmem_addr]),
    .display_instruction_memory_value(instr_mem[b_imem_addr]),
    .out_valid(b_valid), .out_ready(out_ready), .out_data(b_data),
    .out_address(b_addr), .out_source(b_src), .busy(b_busy), .done(b_done)
  );

  // Observation view of whichever instance the current scan targets.
  logic        obs_valid, obs_busy, obs_done;
  logic [31:0] obs_data;
  logic [5:0]  obs_addr;
  logic [1:0]  obs_src;
  logic [5:0]  obs_port_addr [3];

  assign obs_valid = use_b ? b_valid : a_valid;
  assign obs_busy  = use_b ? b_busy  : a_busy;
  assign obs_done  = use_b ? b_done  : a_done;
  assign obs_data  = use_b ? b_data  : a_data;
  assign obs_addr  = use_b ? b_addr  : a_addr;
  assign obs_src   = use_b ? b_src   : a_src;
  assign obs_port_addr[0] = use_b ? b_reg_addr  : a_reg_addr;
  assign obs_port_addr[1] = use_b ? b_dmem_addr : a_dmem_addr;
  assign obs_port_addr[2] = use_b ? b_imem_addr : a_imem_addr;

  // Contents a correct scan must return for a given source and address.
  function automatic logic [31:0] refValue(input logic [1:0] src, input int a);
    case (src)
      2'd0:    return 32'h100 + a;
      2'd1:    return data_mem[a];
      default: return instr_mem[a];
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic [1:0] src, input logic rdy);
    start         = s;
    source_select = src;
    out_ready     = rdy;
  endtask

  // Everything the selected instance drives must be at its reset value.
  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_valid"}, {31'd0, obs_valid}, 32'd0);
    checkOutput({tag, "_busy"},  {31'd0, obs_busy},  32'd0);
    checkOutput({tag, "_done"},  {31'd0, obs_done},  32'd0);
    checkOutput({tag, "_data"},  obs_data, 32'd0);
    checkOutput({tag, "_addr"},  {26'd0, obs_addr}, 32'd0);
    checkOutput({tag, "_src"},   {30'd0, obs_src},  32'd0);
    for (int p = 0; p < 3; p++)
      checkOutput({tag, "_port_addr"}, {26'd0, obs_port_addr[p]}, 32'd0);
  endtask

  // One scan. mode 0: always ready, 1: random ready, 2: ready held low for
  // 10 cycles while address 5 is presented. abort_addr asserts reset while
  // that address is presented; restart_addr re-pulses start during that word.
  task automatic runScan(input logic [1:0] src, input int mode,
                         input int abort_addr, input int restart_addr);
    int  w, last, next_addr, elapsed, busy_cycles, words, budget, hold_left;
    bit  pending, done_phase, finished, exp_valid, rdy, accept;
    w           = use_b ? 3 : 2;
    last        = use_b ? 0 : 63;
    next_addr   = 0;
    elapsed     = 0;
    busy_cycles = 0;
    words       = 0;
    budget      = 0;
    hold_left   = 10;
    pending     = 1'b1;
    done_phase  = 1'b0;
    finished    = 1'b0;

    applyStimulus(1'b1, src, 1'b1);
    @(posedge clock); #1;
    applyStimulus(1'b0, 2'($urandom_range(0, 3)), 1'b1);

    while (!finished && budget < 5000) begin
      budget++;
      if (obs_busy) busy_cycles++;
      if (done_phase) begin
        checkOutput("done_pulse", {31'd0, obs_done},  32'd1);
        checkOutput("done_busy",  {31'd0, obs_busy},  32'd1);
        checkOutput("done_valid", {31'd0, obs_valid}, 32'd0);
        @(posedge clock); #1;
        checkOutput("after_done",      {31'd0, obs_done}, 32'd0);
        checkOutput("after_done_busy", {31'd0, obs_busy}, 32'd0);
        finished = 1'b1;
      end else begin
        exp_valid = pending && (elapsed >= w);
        checkOutput("valid", {31'd0, obs_valid}, {31'd0, exp_valid});
        checkOutput("busy",  {31'd0, obs_busy},  32'd1);
        checkOutput("done",  {31'd0, obs_done},  32'd0);
        for (int p = 0; p < 3; p++)
          checkOutput("port_addr", {26'd0, obs_port_addr[p]},
                      (p == int'(src)) ? next_addr : 0);
        if (exp_valid) begin
          checkOutput("data", obs_data, refValue(src, next_addr));
          checkOutput("addr", {26'd0, obs_addr}, next_addr);
          checkOutput("src",  {30'd0, obs_src},  {30'd0, src});
        end
        if (exp_valid && next_addr == abort_addr) begin
          reset = 1'b1;
          #1;
          checkIdleOutputs("abort");
          reset = 1'b0;
          return;
        end
        if (next_addr == restart_addr && elapsed == 0)
          start = 1'b1;
        case (mode)
          0: rdy = 1'b1;
          1: rdy = 1'($urandom_range(0, 1));
          default: begin
            rdy = 1'b1;
            if (exp_valid && next_addr == 5 && hold_left > 0) begin
              rdy = 1'b0;
              hold_left--;
            end
          end
        endcase
        out_ready = rdy;
        accept = exp_valid && rdy;
        @(posedge clock); #1;
        start         = 1'b0;
        source_select = 2'($urandom_range(0, 3));
        if (accept) begin
          words++;
          elapsed = 0;
          if (next_addr == last) begin
            pending    = 1'b0;
            done_phase = 1'b1;
          end else begin
            next_addr++;
          end
        end else begin
          elapsed++;
        end
      end
    end

    checkOutput("scan_timeout", {31'd0, finished}, 32'd1);
    checkOutput("word_count", words, last + 1);
    if (mode == 0)
      checkOutput("busy_cycles", busy_cycles, (last + 1) * (w + 1) + 1);
    if (mode == 2)
      checkOutput("hold_used", hold_left, 0);
    out_ready = 1'b1;
    @(posedge clock); #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      data_mem[i]  = $urandom;
      instr_mem[i] = $urandom;
    end

    // Reset values, both while held and after release.
    applyStimulus(1'b0, 2'd0, 1'b0);
    repeat (3) @(posedge clock);
    #1;
    checkIdleOutputs("reset_held");
    reset = 1'b0;
    @(posedge clock); #1;
    checkIdleOutputs("reset_released");

    // Reserved source: start is ignored entirely.
    applyStimulus(1'b1, 2'd3, 1'b1);
    @(posedge clock); #1;
    start = 1'b0;
    repeat (4) begin
      checkIdleOutputs("reserved_src");
      @(posedge clock); #1;
    end

    $display("[TB] full register file scan, always ready");
    runScan(2'd0, 0, -1, -1);
    $display("[TB] data memory scan with backpressure at address 5");
    runScan(2'd1, 2, -1, -1);
    $display("[TB] instruction memory scan with random ready");
    runScan(2'd2, 1, -1, -1);
    $display("[TB] reset during address 20, then fresh scan");
    runScan(2'd0, 0, 20, -1);
    runScan(2'd1, 1, -1, -1);
    $display("[TB] extra start pulse during address 30");
    runScan(2'd2, 0, -1, 30);
    $display("[TB] single-word scan on instance with LAST_ADDRESS=0");
    use_b = 1'b1;
    runScan(2'd2, 0, -1, -1);
    runScan(2'd0, 1, -1, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
